q_max_finder: RTL and testbench
===============================

Name: q_max_finder

Overview:
- Upstream stage of the Q-update datapath.
- For a given next-state index, it reads every action's Q value from the Q-table RAM, one per cycle.
- It tracks the signed maximum and presents it as max_Q to the Q-update stage through a valid/ready handshake.
- It is the only reader of the next-state row during an update. The Q-table itself is external synchronous RAM with 1-cycle read latency.

Parameters:
- N_ACTIONS, 4, actions per state. Must be a power of two, >= 2.
- STATE_W, 4, state index width.
- Q_W, 16, Q-value width; two's complement signed.
- ACT_W, $clog2(N_ACTIONS), derived localparam, action index width.
- ADDR_W, STATE_W+ACT_W, derived localparam, Q-table address width.

Ports:
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request a max search; accepted only when busy=0
- state_in  in  STATE_W  next-state index; sampled on the accepted start
- busy  out  1  high from the cycle after an accepted start until the output handshake completes
- mem_en  out  1  Q-table read enable
- mem_addr  out  ADDR_W  read address = {state, action}
- mem_rdata  in  Q_W  Q-table read data, valid 1 cycle after mem_en
- max_q  out  Q_W  maximum Q of the row; feeds the Q-update max_Q input
- max_valid  out  1  max_q valid; held until accepted
- max_ready  in  1  downstream accepts max_q when max_valid=1

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high.
- Reset values: busy=0, mem_en=0, mem_addr=0, max_q=0, max_valid=0, FSM=IDLE, action counter=0. Optional best_action=0.
- FSM states: IDLE, READ, LAST, HOLD.
- IDLE:
  - On start=1, latch state_in and go to READ.
  - start while busy=1 is ignored; no queueing.
- READ:
  - mem_en=1 and mem_addr={state_lat, cnt}, with cnt running 0..N_ACTIONS-1, one address per cycle.
  - After issuing cnt=N_ACTIONS-1, go to LAST.
- Compare pipeline:
  - A registered flag marks that rdata is valid the cycle after each mem_en.
  - First return (action 0) loads the accumulator unconditionally.
  - Each later return replaces it only if signed(mem_rdata) > signed(acc).
  - Ties keep the lower action index.
- LAST:
  - mem_en=0; the final return is compared here.
  - Then max_q <= acc result, max_valid <= 1, go to HOLD.
- HOLD:
  - max_q and max_valid stay stable.
  - On max_valid && max_ready, go to IDLE: max_valid=0 and busy=0 the next cycle.
  - A start in that same cycle is ignored.
- Latency: start sampled at edge E0.
  - mem_en high for exactly N_ACTIONS cycles after E0.
  - max_valid rises at edge E0+N_ACTIONS+1.
  - With max_ready tied high, start-to-start throughput is N_ACTIONS+3 cycles.
- Arithmetic: compare only, no saturation or wrap. The most negative value (0x8000) is a legal maximum when all entries equal it.
- Reset mid-operation: abort immediately to reset values; the in-flight RAM return is discarded.
- state_in changing after acceptance has no effect.

Optional Feature:
- Macro QMAX_ARGMAX_EN.
- Defined:
  - Adds output port best_action [ACT_W] (reset 0).
  - Carries the index of the winning entry (lowest index on ties).
  - Valid and stable under the same max_valid/max_ready handshake.
  - Used by the greedy action selector.
- Undefined: the port and its index register are absent; all other behaviour is identical.

Decomposition:
- Shared package qlearn_pkg holds:
  - Q_W, Q_T (signed [Q_W-1:0]), STATE_W.
  - The FSM state enum qmax_state_t {IDLE, READ, LAST, HOLD}.
  - Address-build function q_addr(state, action).
- Natural sub-module: q_max_acc. It is the registered compare/accumulate unit (load, valid-in, data-in, acc out, index out). The FSM and address counter stay in the top.

Test Plan:
- Row {100, -5, 300, 20}, start, max_ready=1:
  - mem_addr visits {s,0}..{s,3} on consecutive cycles.
  - max_q=300, best_action=2.
  - max_valid rises 5 cycles after start.
- Row all 0x8000 (most negative) -> max_q=0x8000, best_action=0.
- Row {7, 7, 3, 7} (ties) -> max_q=7, best_action=0.
- max_ready held low 10 cycles with row {-1, -2, -3, -4}:
  - max_q=0xFFFF stays stable and busy stays high.
  - A start issued during the hold is ignored (no mem_en).
  - Handshake completes on the first max_ready=1.
- rst pulsed on the 2nd READ cycle:
  - Next cycle all outputs are at reset values.
  - A fresh start with row {1, 2, 3, 4} -> max_q=4.
- Back-to-back with state_in=3 then 5, max_ready=1:
  - Addresses 12..15 then 20..23.
  - Second start accepted only after busy falls; each max_q matches its own row.

Source files
------------

// File: rtl/qlearn_pkg.sv
// Shared Q-learning datapath types: widths, Q value type, max-finder FSM states
// and the Q-table address builder.
package qlearn_pkg;

   localparam int unsigned Q_W     = 16;
   localparam int unsigned STATE_W = 4;

   typedef logic signed [Q_W-1:0] q_t;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      LAST,
      HOLD
   } qmax_state_t;

   // Q-table address is {state, action}; act_w is the action field width.
   function automatic logic [31:0] q_addr(input logic [31:0] state,
                                          input logic [31:0] action,
                                          input int unsigned act_w);
      return (state << act_w) | action;
   endfunction

endpackage

// File: rtl/q_max_acc.sv
// Registered signed-max accumulator: load takes the first value, later values
// replace it only when strictly greater (ties keep the earlier index).
// With QMAX_ARGMAX_EN defined it also tracks the index of the winning entry.
module q_max_acc #(
   parameter int unsigned Q_W = 16
`ifdef QMAX_ARGMAX_EN
   ,parameter int unsigned ACT_W = 2
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  vld,
   input  logic signed [Q_W-1:0] din,
`ifdef QMAX_ARGMAX_EN
   input  logic [ACT_W-1:0]      idx_in,
   output logic [ACT_W-1:0]      idx_c,
`endif
   output logic signed [Q_W-1:0] acc_c
);

   logic signed [Q_W-1:0] acc;
   logic                  take_c;

   always_comb take_c = vld && (load || (din > acc));
   always_comb acc_c  = take_c ? din : acc;

   always_ff @(posedge clk) begin
      if (rst) acc <= '0;
      else     acc <= acc_c;
   end

`ifdef QMAX_ARGMAX_EN
   logic [ACT_W-1:0] idx;

   always_comb idx_c = take_c ? idx_in : idx;

   always_ff @(posedge clk) begin
      if (rst) idx <= '0;
      else     idx <= idx_c;
   end
`endif

endmodule

// File: rtl/q_max_finder.sv
// Reads one Q-table row (one action per cycle) and presents its signed maximum
// over a valid/ready handshake. QMAX_ARGMAX_EN adds the best_action output.
module q_max_finder #(
   parameter int unsigned N_ACTIONS = 4,
   parameter int unsigned STATE_W   = qlearn_pkg::STATE_W,
   parameter int unsigned Q_W       = qlearn_pkg::Q_W
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start,
   input  logic [STATE_W-1:0]                     state_in,
   output logic                                   busy,
   output logic                                   mem_en,
   output logic [STATE_W+$clog2(N_ACTIONS)-1:0]   mem_addr,
   input  logic [Q_W-1:0]                         mem_rdata,
   output logic [Q_W-1:0]                         max_q,
   output logic                                   max_valid,
   input  logic                                   max_ready
`ifdef QMAX_ARGMAX_EN
   ,output logic [$clog2(N_ACTIONS)-1:0]          best_action
`endif
);
   import qlearn_pkg::*;

   localparam int unsigned ACT_W  = $clog2(N_ACTIONS);
   localparam int unsigned ADDR_W = STATE_W + ACT_W;
   localparam logic [ACT_W-1:0] CNT_LAST = ACT_W'(N_ACTIONS - 1);

   qmax_state_t          state, state_nxt;
   logic [ACT_W-1:0]     cnt, cnt_nxt;
   logic [STATE_W-1:0]   state_lat, lat_nxt;
   logic                 en_nxt, busy_nxt, valid_nxt;
   logic [ADDR_W-1:0]    addr_nxt;
   logic [Q_W-1:0]       q_nxt;
   logic                 rvalid;
   logic [ACT_W-1:0]     rcnt;
   logic signed [Q_W-1:0] acc_c;
`ifdef QMAX_ARGMAX_EN
   logic [ACT_W-1:0]     idx_c, best_nxt;
`endif

   // rcnt is the action index of the RAM word returning this cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         rvalid <= 1'b0;
         rcnt   <= '0;
      end else begin
         rvalid <= mem_en;
         if (mem_en) rcnt <= cnt;
      end
   end

   q_max_acc #(
      .Q_W   (Q_W)
`ifdef QMAX_ARGMAX_EN
      ,.ACT_W(ACT_W)
`endif
   ) u_acc (
      .clk    (clk),
      .rst    (rst),
      .load   (rcnt == '0),
      .vld    (rvalid),
      .din    (mem_rdata),
`ifdef QMAX_ARGMAX_EN
      .idx_in (rcnt),
      .idx_c  (idx_c),
`endif
      .acc_c  (acc_c)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         state_lat <= '0;
         mem_en    <= 1'b0;
         mem_addr  <= '0;
         busy      <= 1'b0;
         max_q     <= '0;
         max_valid <= 1'b0;
`ifdef QMAX_ARGMAX_EN
         best_action <= '0;
`endif
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         state_lat <= lat_nxt;
         mem_en    <= en_nxt;
         mem_addr  <= addr_nxt;
         busy      <= busy_nxt;
         max_q     <= q_nxt;
         max_valid <= valid_nxt;
`ifdef QMAX_ARGMAX_EN
         best_action <= best_nxt;
`endif
      end
   end

   // Next-state and next registered-output values.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      lat_nxt   = state_lat;
      en_nxt    = 1'b0;
      addr_nxt  = mem_addr;
      busy_nxt  = busy;
      q_nxt     = max_q;
      valid_nxt = max_valid;
`ifdef QMAX_ARGMAX_EN
      best_nxt  = best_action;
`endif
      case (state)
         IDLE: begin
            if (start) begin
               lat_nxt   = state_in;
               cnt_nxt   = '0;
               en_nxt    = 1'b1;
               addr_nxt  = ADDR_W'(q_addr(32'(state_in), 32'd0, ACT_W));
               busy_nxt  = 1'b1;
               state_nxt = READ;
            end
         end
         READ: begin
            if (cnt == CNT_LAST) begin
               state_nxt = LAST;
            end else begin
               cnt_nxt  = cnt + ACT_W'(1);
               en_nxt   = 1'b1;
               addr_nxt = ADDR_W'(q_addr(32'(state_lat), 32'(cnt_nxt), ACT_W));
            end
         end
         LAST: begin
            // Final RAM word is compared in this cycle via the accumulator bypass.
            q_nxt     = acc_c;
            valid_nxt = 1'b1;
`ifdef QMAX_ARGMAX_EN
            best_nxt  = idx_c;
`endif
            state_nxt = HOLD;
         end
         HOLD: begin
            if (max_ready) begin
               valid_nxt = 1'b0;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_q_max_finder.sv
// Self-checking bench for q_max_finder: transaction-level reference model with a
// per-cycle compare process, directed cases plus randomized rows and handshakes.
module tb_q_max_finder;

   localparam int unsigned N   = 4;
   localparam int unsigned SW  = 4;
   localparam int unsigned QW  = 16;
   localparam int unsigned AW  = 2;
   localparam int unsigned ADW = 6;

   logic           clk = 1'b0;
   logic           rst, start, busy, mem_en, max_valid, max_ready;
   logic [SW-1:0]  state_in;
   logic [ADW-1:0] mem_addr;
   logic [QW-1:0]  mem_rdata, max_q;
`ifdef QMAX_ARGMAX_EN
   logic [AW-1:0]  best_action;
`endif

   q_max_finder #(.N_ACTIONS(N), .STATE_W(SW), .Q_W(QW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .state_in  (state_in),
      .busy      (busy),
      .mem_en    (mem_en),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .max_q     (max_q),
      .max_valid (max_valid),
      .max_ready (max_ready)
`ifdef QMAX_ARGMAX_EN
      ,.best_action(best_action)
`endif
   );

   always #5 clk = ~clk;

   // Q-table: synchronous RAM with one-cycle read latency.
   logic [QW-1:0] mem [0:(1<<ADW)-1];
   always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr];

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: k counts cycles since the accepted start (0 = idle).
   int                   k = 0;
   int                   m_state = 0;
   logic signed [QW-1:0] m_q = '0;
   int                   m_best = 0;
   logic signed [QW-1:0] mv;
   bit                   chk_en = 1'b0;

   always @(posedge clk) begin
      if (rst) begin
         k = 0;
      end else if (k == 0) begin
         if (start) begin
            k = 1;
            m_state = int'(state_in);
            for (int a = 0; a < N; a++) begin
               mv = mem[m_state*N + a];
               if (a == 0 || mv > m_q) begin
                  m_q    = mv;
                  m_best = a;
               end
            end
         end
      end else if (k >= N+2 && max_ready) begin
         k = 0;
      end else begin
         k++;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("busy",      32'(busy),      32'(k > 0));
         check("mem_en",    32'(mem_en),    32'(k >= 1 && k <= N));
         if (k >= 1 && k <= N)
            check("mem_addr", 32'(mem_addr), 32'(m_state*N + k - 1));
         check("max_valid", 32'(max_valid), 32'(k >= N+2));
         if (k >= N+2) begin
            check("max_q", 32'(max_q), {16'd0, m_q});
`ifdef QMAX_ARGMAX_EN
            check("best_action", 32'(best_action), 32'(m_best));
`endif
         end
      end
   end

   task automatic load_row(input int s, input int v0, input int v1, input int v2, input int v3);
      mem[s*N + 0] = 16'(v0);
      mem[s*N + 1] = 16'(v1);
      mem[s*N + 2] = 16'(v2);
      mem[s*N + 3] = 16'(v3);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("idle_timeout", 32'(busy), 32'd0);
   endtask

   task automatic do_start(input int s);
      state_in = SW'(s);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      state_in = SW'($urandom);
   endtask

   // Counts clock edges after the accepted start until max_valid is seen.
   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (!max_valid && cyc < 60) begin
         @(negedge clk);
         cyc++;
      end
      if (!max_valid) check("valid_timeout", 32'(max_valid), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"},  32'(busy),      32'd0);
      check({tag, "_en"},    32'(mem_en),    32'd0);
      check({tag, "_addr"},  32'(mem_addr),  32'd0);
      check({tag, "_maxq"},  32'(max_q),     32'd0);
      check({tag, "_valid"}, 32'(max_valid), 32'd0);
`ifdef QMAX_ARGMAX_EN
      check({tag, "_best"},  32'(best_action), 32'd0);
`endif
   endtask

   initial begin
      int cyc;
      int j;
      int s;
      rst = 1'b1; start = 1'b0; state_in = '0; max_ready = 1'b1;
      for (int i = 0; i < (1<<ADW); i++) mem[i] = '0;
      repeat (3) @(negedge clk);
      check_reset_outputs("por");
      rst = 1'b0;
      chk_en = 1'b1;

      // Mixed-sign row, latency and argmax.
      load_row(1, 100, -5, 300, 20);
      do_start(1);
      wait_valid(cyc);
      check("t1_latency", 32'(cyc), 32'd5);
      check("t1_max_q", 32'(max_q), 32'd300);
      check("t1_model", {16'd0, m_q}, 32'd300);
`ifdef QMAX_ARGMAX_EN
      check("t1_best", 32'(best_action), 32'd2);
`endif

      // All most-negative.
      wait_idle();
      load_row(2, -32768, -32768, -32768, -32768);
      do_start(2);
      wait_valid(cyc);
      check("t2_max_q", 32'(max_q), 32'h8000);
`ifdef QMAX_ARGMAX_EN
      check("t2_best", 32'(best_action), 32'd0);
`endif

      // Ties keep the lowest index.
      wait_idle();
      load_row(4, 7, 7, 3, 7);
      do_start(4);
      wait_valid(cyc);
      check("t3_max_q", 32'(max_q), 32'd7);
`ifdef QMAX_ARGMAX_EN
      check("t3_best", 32'(best_action), 32'd0);
`endif

      // Backpressure: hold, ignored start, then release.
      wait_idle();
      load_row(6, -1, -2, -3, -4);
      max_ready = 1'b0;
      do_start(6);
      wait_valid(cyc);
      for (int i = 0; i < 10; i++) begin
         start = (i == 3);
         check("t4_hold_q", 32'(max_q), 32'hFFFF);
         check("t4_hold_busy", 32'(busy), 32'd1);
         @(negedge clk);
      end
      start = 1'b0;
      max_ready = 1'b1;
      @(negedge clk);
      check("t4_rel_valid", 32'(max_valid), 32'd0);
      check("t4_rel_busy", 32'(busy), 32'd0);

      // Reset on the second READ cycle, then a clean search.
      load_row(9, 50, 60, 70, 80);
      do_start(9);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_outputs("t5_rst");
      load_row(10, 1, 2, 3, 4);
      do_start(10);
      wait_valid(cyc);
      check("t5_max_q", 32'(max_q), 32'd4);

      // Back-to-back with start held high.
      wait_idle();
      load_row(3, 11, -20, 33, 5);
      load_row(5, -9, 40, 40, -100);
      state_in = SW'(3);
      start = 1'b1;
      @(negedge clk);
      state_in = SW'(5);
      j = 1;
      while (!(mem_en && mem_addr == ADW'(20)) && j < 40) begin
         @(negedge clk);
         j++;
      end
      start = 1'b0;
      check("t6_throughput", 32'(j - 1), 32'd7);
      wait_valid(cyc);
      check("t6_max_q", 32'(max_q), 32'd40);

      // Randomized rows, starts and backpressure.
      for (int it = 0; it < 25; it++) begin
         wait_idle();
         @(negedge clk);
         s = $urandom_range(0, 15);
         for (int a = 0; a < N; a++) mem[s*N + a] = 16'($urandom);
         if ($urandom_range(0, 3) == 0) mem[s*N + 3] = mem[s*N + 1];
         do_start(s);
         repeat ($urandom_range(6, 20)) begin
            max_ready = 1'($urandom_range(0, 1));
            start     = 1'($urandom_range(0, 1));
            state_in  = SW'($urandom);
            @(negedge clk);
         end
         start = 1'b0;
         max_ready = 1'b1;
      end
      wait_idle();
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
